psum_binarizer: RTL and testbench

Output stage directly downstream of the partial-sum accumulator array. It drives the array's pop port and drains all O_CH×OUT_ROW_LENGTH partial sums. Each sum is binarized against a per-output-channel threshold, giving 1 when the sum is at or above the threshold. The bits are regrouped into one O_CH-bit activation word per output pixel and streamed to the next layer's input formatter over a valid/ready handshake.

---
 rtl/bnn_pkg.sv | 23 ++
 rtl/thr_bank.sv | 57 +++++
 rtl/psum_binarizer.sv | 160 ++++++++++++++++
 tb/tb_psum_binarizer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the partial-sum accumulator and its output stage.
//   DEF_WIDTH          default bit width of partial sums and thresholds
//   DEF_OUT_ROW_LENGTH default output pixels per row held by the accumulator
//   DEF_O_CH           default number of output channels
//   POP_LEN            partial sums drained per row (O_CH x OUT_ROW_LENGTH)
//   state_e            binarizer FSM encoding (IDLE=0, POP=1, EMIT=2)
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int DEF_WIDTH          = 14;
  localparam int DEF_OUT_ROW_LENGTH = 4;
  localparam int DEF_O_CH           = 64;
  localparam int POP_LEN            = DEF_O_CH * DEF_OUT_ROW_LENGTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/thr_bank.sv
// -----------------------------------------------------------------------------
// thr_bank
// Per-output-channel threshold registers with a burst-load write port.
//   clk_in      clock, rising edge
//   rst_in      synchronous active-high reset; clears every threshold and idx
//   load_en_in  write strobe; consecutive high cycles write consecutive indices
//   thr_in      value written to thr[idx] while load_en_in is high
//   rd_ch_in    channel selecting the combinational read port
//   rd_thr_out  thr[rd_ch_in]
// The load index returns to 0 in any cycle without a write, so every burst
// starts at channel 0. A burst longer than O_CH wraps back to channel 0.
// -----------------------------------------------------------------------------
module thr_bank
  import bnn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int O_CH  = DEF_O_CH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    load_en_in,
  input  logic [WIDTH-1:0]        thr_in,
  input  logic [$clog2(O_CH)-1:0] rd_ch_in,
  output logic [WIDTH-1:0]        rd_thr_out
);

  localparam int CH_W = $clog2(O_CH);

  logic [WIDTH-1:0] thr_q [O_CH];
  logic [WIDTH-1:0] thr_d [O_CH];
  logic [CH_W-1:0]  idx_q;
  logic [CH_W-1:0]  idx_d;

  always_comb begin
    thr_d = thr_q;
    idx_d = '0;
    if (load_en_in) begin
      thr_d[idx_q] = thr_in;
      idx_d        = (idx_q == CH_W'(O_CH - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < O_CH; i++) begin
        thr_q[i] <= '0;
      end
      idx_q <= '0;
    end else begin
      thr_q <= thr_d;
      idx_q <= idx_d;
    end
  end

  assign rd_thr_out = thr_q[rd_ch_in];

endmodule

// File: rtl/psum_binarizer.sv
// -----------------------------------------------------------------------------
// psum_binarizer
// Drains the partial-sum accumulator, binarizes each sum against its channel
// threshold and streams one O_CH-bit activation word per output pixel.
//   clk_in         clock, rising edge
//   rst_in         synchronous active-high reset
//   start_in       begin a drain (honoured in IDLE only, never queued)
//   busy_out       high in POP and EMIT
//   thr_load_in    threshold load strobe (IDLE only)
//   thr_in         threshold for the current load index
//   pop_out        registered pop request, high for exactly POP_LEN cycles
//   sum_in         popped partial sum, valid every cycle pop_out is high
//   act_valid_out  activation word valid
//   act_ready_in   downstream ready
//   act_out        activation word, bit c = channel c
//   act_last_out   high with the word for pixel OUT_ROW_LENGTH-1
//   dbg_state_out  current FSM state (state_e encoding)
//
// Handshake: a word transfers on a rising edge where act_valid_out and
// act_ready_in are both high. Once act_valid_out rises it stays high, and
// act_out/act_last_out stay stable, until that transfer happens; ready may
// toggle freely and has no combinational path to any output.
//
// Element k of the drain belongs to channel k/OUT_ROW_LENGTH and pixel
// OUT_ROW_LENGTH-1-(k mod OUT_ROW_LENGTH): the accumulator pops each channel's
// pixels highest first. OUT_ROW_LENGTH and O_CH are assumed powers of two.
// -----------------------------------------------------------------------------
module psum_binarizer
  import bnn_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int OUT_ROW_LENGTH = DEF_OUT_ROW_LENGTH,
  parameter int O_CH           = DEF_O_CH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  output logic             busy_out,
  input  logic             thr_load_in,
  input  logic [WIDTH-1:0] thr_in,
  output logic             pop_out,
  input  logic [WIDTH-1:0] sum_in,
  output logic             act_valid_out,
  input  logic             act_ready_in,
  output logic [O_CH-1:0]  act_out,
  output logic             act_last_out,
  output logic [1:0]       dbg_state_out
);

  localparam int POP_N = O_CH * OUT_ROW_LENGTH;
  localparam int CH_W  = $clog2(O_CH);
  localparam int PIX_W = $clog2(OUT_ROW_LENGTH);
  localparam int CNT_W = $clog2(POP_N);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [PIX_W-1:0]  emit_cnt_q, emit_cnt_d;
  logic [O_CH-1:0]   pix_buf_q [OUT_ROW_LENGTH];
  logic [O_CH-1:0]   pix_buf_d [OUT_ROW_LENGTH];
  logic              pop_q, pop_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic [CH_W-1:0]   cur_ch;
  logic [PIX_W-1:0]  cur_pix;
  logic [WIDTH-1:0]  cur_thr;
  logic              cur_bit;
  logic              load_en;
  logic              emit_last;

  // Channel is the upper counter bits; pixel index counts down within a channel.
  assign cur_ch  = pop_cnt_q[CNT_W-1:PIX_W];
  assign cur_pix = PIX_W'(OUT_ROW_LENGTH - 1) - pop_cnt_q[PIX_W-1:0];
  assign cur_bit = ($signed(sum_in) >= $signed(cur_thr));

  assign load_en   = thr_load_in && (state_q == IDLE);
  assign emit_last = (emit_cnt_q == PIX_W'(OUT_ROW_LENGTH - 1));

  thr_bank #(
    .WIDTH (WIDTH),
    .O_CH  (O_CH)
  ) u_thr_bank (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load_en_in (load_en),
    .thr_in     (thr_in),
    .rd_ch_in   (cur_ch),
    .rd_thr_out (cur_thr)
  );

  always_comb begin
    state_d    = state_q;
    pop_cnt_d  = pop_cnt_q;
    emit_cnt_d = emit_cnt_q;
    pix_buf_d  = pix_buf_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d   = POP;
          pop_cnt_d = '0;
        end
      end
      POP: begin
        pix_buf_d[cur_pix][cur_ch] = cur_bit;
        pop_cnt_d                  = pop_cnt_q + 1'b1;
        if (pop_cnt_q == CNT_W'(POP_N - 1)) begin
          state_d    = EMIT;
          pop_cnt_d  = '0;
          emit_cnt_d = '0;
        end
      end
      EMIT: begin
        if (valid_q && act_ready_in) begin
          if (emit_last) begin
            state_d    = IDLE;
            emit_cnt_d = '0;
          end else begin
            emit_cnt_d = emit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Output flags are registered from the next state so they line up with it.
    pop_d   = (state_d == POP);
    valid_d = (state_d == EMIT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      pop_cnt_q  <= '0;
      emit_cnt_q <= '0;
      for (int i = 0; i < OUT_ROW_LENGTH; i++) begin
        pix_buf_q[i] <= '0;
      end
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_cnt_q  <= pop_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      pix_buf_q  <= pix_buf_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  // The buffer is not written in EMIT, so the selected word holds under stall.
  assign act_out       = valid_q ? pix_buf_q[emit_cnt_q] : '0;
  assign act_last_out  = valid_q && emit_last;
  assign act_valid_out = valid_q;
  assign pop_out       = pop_q;
  assign busy_out      = busy_q;
  assign dbg_state_out = state_q;

endmodule

// File: tb/tb_psum_binarizer.sv
module tb_psum_binarizer;

  localparam int N = 256;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        busy_out;
  logic        thr_load_in;
  logic [13:0] thr_in;
  logic        pop_out;
  logic [13:0] sum_in;
  logic        act_valid_out;
  logic        act_ready_in;
  logic [63:0] act_out;
  logic        act_last_out;
  logic [1:0]  dbg_state_out;

  int total = 0;
  int bad   = 0;

  logic [13:0] sums [N];
  logic [63:0] got_w [4];
  logic        got_l [4];
  logic [63:0] exp_w [4];
  int          got_n;
  int          emit_cycles;
  int          npop;
  logic        busy_ok;

  always #5 clk = ~clk;

  psum_binarizer dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .busy_out      (busy_out),
    .thr_load_in   (thr_load_in),
    .thr_in        (thr_in),
    .pop_out       (pop_out),
    .sum_in        (sum_in),
    .act_valid_out (act_valid_out),
    .act_ready_in  (act_ready_in),
    .act_out       (act_out),
    .act_last_out  (act_last_out),
    .dbg_state_out (dbg_state_out)
  );

  // ---------------- clock / reset ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_in = 1'b1; start_in = 1'b0; thr_load_in = 1'b0; thr_in = '0;
    sum_in = '0; act_ready_in = 1'b1;
    tick; tick;
    rst_in = 1'b0;
  endtask

  // ---------------- drivers ----------------
  // Load thr[0..4]=0 and thr[5]=v5 in one burst starting at index 0.
  task automatic load_thr6(input logic [13:0] v5);
    thr_load_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      thr_in = (i == 5) ? v5 : 14'd0;
      tick;
    end
    thr_load_in = 1'b0; thr_in = '0;
    tick;
  endtask

  task automatic load_ramp(input int n);
    thr_load_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      thr_in = 14'(i);
      tick;
    end
    thr_load_in = 1'b0; thr_in = '0;
    tick;
  endtask

  // Pulse start, then feed sums[k] while pop_out is high. Optionally pulse
  // thr_load_in for 3 cycles from pop load_at, or reset at pop rst_at.
  task automatic run_drain(input int rst_at, input int load_at);
    int k;
    k = 0;
    busy_ok = 1'b1;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    while (pop_out === 1'b1 && k < N + 8) begin
      sum_in = (k < N) ? sums[k] : 14'd0;
      if (busy_out !== 1'b1) busy_ok = 1'b0;
      thr_load_in = (load_at >= 0 && k >= load_at && k < load_at + 3);
      thr_in = thr_load_in ? 14'h2000 : 14'd0;
      if (k == rst_at) begin
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
        k++;
        break;
      end
      tick;
      k++;
    end
    thr_load_in = 1'b0; thr_in = '0; sum_in = '0;
    npop = k;
  endtask

  // Collect up to 4 words. mode 0: ready always high. mode 1: ready low for
  // 10 cycles then high on even cycles. start_in pulsed at cycle start_at.
  task automatic collect(input int mode, input int start_at);
    int i;
    logic        prev_stall;
    logic [63:0] prev_word;
    logic        prev_last;
    got_n = 0; prev_stall = 1'b0; prev_word = '0; prev_last = 1'b0;
    for (i = 0; i < 100 && got_n < 4; i++) begin
      act_ready_in = (mode == 0) ? 1'b1 : ((i >= 10) && (i % 2 == 0));
      start_in = (i == start_at);
      if (prev_stall) begin
        total++;
        if (act_valid_out !== 1'b1 || act_out !== prev_word || act_last_out !== prev_last) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d: got v=%b w=%h l=%b, want v=1 w=%h l=%b",
                   i, act_valid_out, act_out, act_last_out, prev_word, prev_last);
        end
      end
      if (act_valid_out === 1'b1 && act_ready_in) begin
        got_w[got_n] = act_out;
        got_l[got_n] = act_last_out;
        got_n++;
      end
      prev_stall = (act_valid_out === 1'b1) && !act_ready_in;
      prev_word  = act_out;
      prev_last  = act_last_out;
      tick;
    end
    start_in = 1'b0;
    act_ready_in = 1'b1;
    emit_cycles = i;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset;
    total++;
    if ({pop_out, busy_out, act_valid_out, act_last_out} !== 4'b0 || act_out !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: got pop=%b busy=%b v=%b l=%b w=%h, want all 0",
               pop_out, busy_out, act_valid_out, act_last_out, act_out);
    end
    total++;
    if (dbg_state_out !== 2'd0) begin
      bad++; $display("FAIL reset_state: got %0d want 0", dbg_state_out);
    end
    for (int k = 0; k < N; k++) sums[k] = 14'd0;
    run_drain(-1, -1);
    total++;
    if (npop !== 256 || busy_ok !== 1'b1) begin
      bad++; $display("FAIL reset_pop_len: got pops=%0d busy_ok=%b want 256/1", npop, busy_ok);
    end
    total++;
    if (act_valid_out !== 1'b1 || pop_out !== 1'b0 || busy_out !== 1'b1 || dbg_state_out !== 2'd2) begin
      bad++;
      $display("FAIL reset_first_valid: got v=%b pop=%b busy=%b st=%0d want 1/0/1/2",
               act_valid_out, pop_out, busy_out, dbg_state_out);
    end
    collect(0, -1);
    total++;
    if (got_n !== 4 || emit_cycles !== 4 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_emit: got words=%0d cycles=%0d busy=%b want 4/4/0", got_n, emit_cycles, busy_out);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== ONES) begin
        bad++; $display("FAIL reset_word%0d: got %h want %h", i, got_w[i], ONES);
      end
    end
  endtask

  task automatic test_binarize_basic;
    for (int k = 0; k < N; k++) sums[k] = (k % 2 == 0) ? 14'd1 : 14'h3FFF;
    exp_w[0] = 64'd0; exp_w[1] = ONES; exp_w[2] = 64'd0; exp_w[3] = ONES;
    run_drain(-1, -1);
    collect(0, -1);
    total++;
    if (got_n !== 4 || emit_cycles !== 4) begin
      bad++; $display("FAIL basic_count: got words=%0d cycles=%0d want 4/4", got_n, emit_cycles);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 3)) begin
        bad++;
        $display("FAIL basic_word%0d: got %h last=%b want %h last=%b",
                 i, got_w[i], got_l[i], exp_w[i], (i == 3));
      end
    end
  endtask

  task automatic test_thr_boundary;
    load_thr6(14'd100);
    for (int k = 0; k < N; k++) sums[k] = 14'd0;
    sums[20] = 14'd100; sums[21] = 14'd99; sums[22] = 14'h2000; sums[23] = 14'h1FFF;
    exp_w[0] = ONES; exp_w[1] = ~64'h20; exp_w[2] = ~64'h20; exp_w[3] = ONES;
    run_drain(-1, -1);
    collect(0, -1);
    total++;
    if (got_n !== 4) begin
      bad++; $display("FAIL bound_count: got %0d want 4", got_n);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin
        bad++; $display("FAIL bound_word%0d: got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    load_thr6(14'h2000);
    for (int k = 0; k < N; k++) sums[k] = 14'h2000;
    run_drain(-1, -1);
    collect(0, -1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== 64'h20) begin
        bad++; $display("FAIL bound_min_word%0d: got %h want %h", i, got_w[i], 64'h20);
      end
    end
  endtask

  task automatic test_backpressure;
    load_thr6(14'd0);
    // Channel c sets its bit only in pixel c%4.
    for (int k = 0; k < N; k++) sums[k] = ((3 - (k % 4)) == ((k / 4) % 4)) ? 14'd1 : 14'h3FFF;
    exp_w[0] = 64'h1111_1111_1111_1111; exp_w[1] = 64'h2222_2222_2222_2222;
    exp_w[2] = 64'h4444_4444_4444_4444; exp_w[3] = 64'h8888_8888_8888_8888;
    run_drain(-1, -1);
    collect(1, 3);
    total++;
    if (got_n !== 4 || busy_out !== 1'b0) begin
      bad++; $display("FAIL bp_count: got words=%0d busy=%b want 4/0", got_n, busy_out);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 3)) begin
        bad++;
        $display("FAIL bp_word%0d: got %h last=%b want %h last=%b",
                 i, got_w[i], got_l[i], exp_w[i], (i == 3));
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pop_out !== 1'b0 || dbg_state_out !== 2'd0) begin
        bad++; $display("FAIL bp_start_ignored: got pop=%b st=%0d want 0/0", pop_out, dbg_state_out);
      end
      tick;
    end
  endtask

  task automatic test_thr_load;
    load_ramp(65);
    for (int k = 0; k < N; k++) begin
      case (k % 4)
        0: sums[k] = 14'(k / 4);
        2: sums[k] = 14'(k / 4 + 1);
        default: sums[k] = 14'(k / 4 - 1);
      endcase
    end
    exp_w[0] = 64'd0; exp_w[1] = ~64'd1; exp_w[2] = 64'd0; exp_w[3] = ~64'd1;
    for (int pass = 0; pass < 2; pass++) begin
      run_drain(-1, (pass == 1) ? 50 : -1);
      collect(0, -1);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_w[i] !== exp_w[i]) begin
          bad++; $display("FAIL load_p%0d_word%0d: got %h want %h", pass, i, got_w[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    // Sums from test_thr_load remain; after reset all thresholds are 0.
    run_drain(100, -1);
    total++;
    if (npop !== 101 || pop_out !== 1'b0 || busy_out !== 1'b0 ||
        act_valid_out !== 1'b0 || dbg_state_out !== 2'd0) begin
      bad++;
      $display("FAIL rst_pop: got pops=%0d pop=%b busy=%b v=%b st=%0d want 101/0/0/0/0",
               npop, pop_out, busy_out, act_valid_out, dbg_state_out);
    end
    exp_w[0] = ~64'd1; exp_w[1] = ONES; exp_w[2] = ~64'd1; exp_w[3] = ONES;
    run_drain(-1, -1);
    total++;
    if (npop !== 256 || act_valid_out !== 1'b1) begin
      bad++; $display("FAIL rst_redrain: got pops=%0d v=%b want 256/1", npop, act_valid_out);
    end
    collect(0, -1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin
        bad++; $display("FAIL rst_word%0d: got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    // Reset while stalled in EMIT.
    run_drain(-1, -1);
    act_ready_in = 1'b0;
    tick;
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    act_ready_in = 1'b1;
    total++;
    if (act_valid_out !== 1'b0 || busy_out !== 1'b0 || dbg_state_out !== 2'd0 || act_out !== 64'd0) begin
      bad++;
      $display("FAIL rst_emit: got v=%b busy=%b st=%0d w=%h want 0/0/0/0",
               act_valid_out, busy_out, dbg_state_out, act_out);
    end
  endtask

  task automatic test_back_to_back;
    // Two drains with no idle gap beyond the mandatory IDLE cycle.
    for (int k = 0; k < N; k++) sums[k] = (k % 2 == 0) ? 14'h3FFF : 14'd5;
    exp_w[0] = ONES; exp_w[1] = 64'd0; exp_w[2] = ONES; exp_w[3] = 64'd0;
    for (int pass = 0; pass < 2; pass++) begin
      run_drain(-1, -1);
      total++;
      if (npop !== 256) begin
        bad++; $display("FAIL b2b_p%0d_pops: got %0d want 256", pass, npop);
      end
      collect(0, -1);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_w[i] !== exp_w[i]) begin
          bad++; $display("FAIL b2b_p%0d_word%0d: got %h want %h", pass, i, got_w[i], exp_w[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_binarize_basic;
    test_thr_boundary;
    test_backpressure;
    test_thr_load;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
